// File: rtl/pc_pkg.sv
// Shared types for the program-counter generator: redirect sources ordered by
// priority and the stall-hold state machine encoding.
package pc_pkg;

    localparam int unsigned SRC_W = 3;

    typedef enum logic [SRC_W-1:0] {
        SRC_SEQ    = 3'd0,
        SRC_BRANCH = 3'd1,
        SRC_JUMP   = 3'd2,
        SRC_MRET   = 3'd3,
        SRC_TRAP   = 3'd4
    } redirect_src_t;

    typedef enum logic {
        PC_RUN  = 1'b0,
        PC_HOLD = 1'b1
    } pc_state_t;

    // Only software-supplied targets can be misaligned; trap vector and pc+4 are trusted.
    function automatic logic is_checked(redirect_src_t s);
        return (s == SRC_BRANCH) || (s == SRC_JUMP) || (s == SRC_MRET);
    endfunction

endpackage

// File: rtl/pc_src_arbiter.sv
// Fixed-priority next-PC source select with target alignment check.
module pc_src_arbiter
    import pc_pkg::*;
#(
    parameter int unsigned      XLEN        = 32,
    parameter logic [XLEN-1:0]  TRAP_VECTOR = XLEN'(32'h0000_0100),
    parameter bit               ALIGN_C     = 1'b0
) (
    input  logic [XLEN-1:0] pc,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            trap,
    input  logic            mret,
    input  logic [XLEN-1:0] mepc,
    output redirect_src_t   src,
    output logic [XLEN-1:0] target,
    output logic            fault
);

    always_comb begin
        src    = SRC_SEQ;
        target = pc + XLEN'(4);
        if (trap) begin
            src    = SRC_TRAP;
            target = TRAP_VECTOR;
        end else if (mret) begin
            src    = SRC_MRET;
            target = mepc;
        end else if (jump) begin
            src    = SRC_JUMP;
            target = {jump_target[XLEN-1:1], 1'b0};
        end else if (branch_taken) begin
            src    = SRC_BRANCH;
            target = branch_target;
        end
    end

    always_comb begin
        fault = 1'b0;
        if (is_checked(src)) begin
            fault = ALIGN_C ? target[0] : (target[1:0] != 2'b00);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter register with prioritised redirects, a one-deep pending
// redirect held across stalls, and misaligned-target diversion to the trap vector.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter bit               ALIGN_C      = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            branch_taken_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    input  logic            trap_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic [XLEN-1:0] pc_next_o,
    output logic            pending_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] fault_addr_o
);

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    redirect_src_t   pend_src_q, pend_src_d;
    logic [XLEN-1:0] pend_target_q, pend_target_d;
    logic            pend_fault_q, pend_fault_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] fault_addr_q, fault_addr_d;

    redirect_src_t   arb_src;
    logic [XLEN-1:0] arb_target;
    logic            arb_fault;

    logic            use_pending;
    logic [XLEN-1:0] sel_target;
    logic            sel_fault;
    logic [XLEN-1:0] pc_next_c;

    pc_src_arbiter #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR),
        .ALIGN_C     (ALIGN_C)
    ) u_arb (
        .pc            (pc_q),
        .branch_taken  (branch_taken_i),
        .branch_target (branch_target_i),
        .jump          (jump_i),
        .jump_target   (jump_target_i),
        .trap          (trap_i),
        .mret          (mret_i),
        .mepc          (mepc_i),
        .src           (arb_src),
        .target        (arb_target),
        .fault         (arb_fault)
    );

    // A held redirect wins unless the live request strictly outranks it.
    always_comb begin
        use_pending = (state_q == PC_HOLD) && (arb_src <= pend_src_q);
        sel_target  = use_pending ? pend_target_q : arb_target;
        sel_fault   = use_pending ? pend_fault_q  : arb_fault;
        pc_next_c   = stall_i ? pc_q : (sel_fault ? TRAP_VECTOR : sel_target);
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_src_d    = pend_src_q;
        pend_target_d = pend_target_q;
        pend_fault_d  = pend_fault_q;
        misalign_d    = 1'b0;
        fault_addr_d  = fault_addr_q;

        if (!stall_i) begin
            pc_d       = pc_next_c;
            state_d    = PC_RUN;
            pend_src_d = SRC_SEQ;
            if (sel_fault) begin
                misalign_d   = 1'b1;
                fault_addr_d = sel_target;
            end
        end else begin
            case (state_q)
                PC_RUN: begin
                    if (arb_src != SRC_SEQ) begin
                        state_d       = PC_HOLD;
                        pend_src_d    = arb_src;
                        pend_target_d = arb_target;
                        pend_fault_d  = arb_fault;
                    end
                end
                PC_HOLD: begin
                    if (arb_src > pend_src_q) begin
                        pend_src_d    = arb_src;
                        pend_target_d = arb_target;
                        pend_fault_d  = arb_fault;
                    end
                end
                default: state_d = PC_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= PC_RUN;
            pc_q          <= RESET_VECTOR;
            pend_src_q    <= SRC_SEQ;
            pend_target_q <= '0;
            pend_fault_q  <= 1'b0;
            misalign_q    <= 1'b0;
            fault_addr_q  <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_src_q    <= pend_src_d;
            pend_target_q <= pend_target_d;
            pend_fault_q  <= pend_fault_d;
            misalign_q    <= misalign_d;
            fault_addr_q  <= fault_addr_d;
        end
    end

    assign pc_o         = pc_q;
    assign pc_plus4_o   = pc_q + XLEN'(4);
    assign pc_next_o    = pc_next_c;
    assign pending_o    = (state_q == PC_HOLD);
    assign misalign_o   = misalign_q;
    assign fault_addr_o = fault_addr_q;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the RISC-V core: owns the PC register and selects the next PC from sequential, branch, jump, trap and mret sources by fixed priority. It generalises the two-input PC select into a multi-source, stall-aware unit that also checks target alignment. When a redirect arrives while the core is stalled, the block holds it and applies it when the stall releases. It sits between the ALU/branch unit, the CSR file and the instruction memory address port.

## Interface
- XLEN, 32, PC width in bits
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset
- TRAP_VECTOR, 32'h0000_0100, PC taken on trap or misaligned redirect
- ALIGN_C, 0, 0 = targets must be 4-byte aligned; 1 = 2-byte aligned (compressed mode)

- clk  in  1  clock, rising-edge
- rst_n  in  1  reset; synchronous, active-low
- stall_i  in  1  hold PC this cycle
- branch_taken_i  in  1  conditional branch resolved taken
- branch_target_i  in  XLEN  branch target
- jump_i  in  1  JAL/JALR redirect
- jump_target_i  in  XLEN  jump target (bit 0 forced to 0 internally)
- trap_i  in  1  exception/interrupt entry
- mret_i  in  1  return from trap
- mepc_i  in  XLEN  return address for mret
- pc_o  out  XLEN  current PC (registered)
- pc_plus4_o  out  XLEN  pc_o + 4, modulo 2^XLEN
- pc_next_o  out  XLEN  value pc_o takes at the next unstalled edge (combinational)
- pending_o  out  1  a redirect is held awaiting stall release
- misalign_o  out  1  one-cycle pulse: the applied redirect target was misaligned
- fault_addr_o  out  XLEN  offending target of the last misaligned redirect

## Operation
- Priority per cycle: trap > mret > jump > branch > sequential (pc_o + 4).
- Candidate target = highest-priority active source; jump target has bit 0 cleared before use.
- Alignment: ALIGN_C=0 faults if target[1:0] != 0; ALIGN_C=1 faults if target[0] != 0. Trap target (TRAP_VECTOR) and sequential PC are never checked.
- Misaligned redirect: pc_o <= TRAP_VECTOR, fault_addr_o <= offending target, misalign_o = 1 for the cycle after the update.
- States: RUN, HOLD.
  - RUN, stall_i=0: pc_o <= selected target.
  - RUN, stall_i=1, no redirect: pc_o holds, stay RUN.
  - RUN, stall_i=1, redirect active: latch source and target into pending, go HOLD, pending_o=1.
  - HOLD, stall_i=1: new redirect of strictly higher priority than pending overwrites it; equal or lower is dropped.
  - HOLD, stall_i=0: apply new redirect if its priority is strictly higher than pending, else apply pending; go RUN, pending_o=0.
- A trap is never dropped: a trap during a stall always replaces a pending redirect.
- pc_plus4_o wraps: 32'hFFFF_FFFC -> 32'h0000_0000.

## Timing
- Reset (rst_n=0 at edge): pc_o=RESET_VECTOR, state RUN, pending_o=0, misalign_o=0, fault_addr_o=0. Reset overrides stall and all redirects in the same cycle.
- Redirect latency: 1 cycle; redirect asserted in cycle N gives pc_o = target after edge N+1 (unstalled).
- Stalled redirect: visible on pc_o one edge after the first cycle with stall_i=0.
- pc_next_o reflects the same selection (including pending) combinationally; during stall it equals pc_o.
- misalign_o asserts in the same cycle pc_o shows TRAP_VECTOR; deasserts next cycle unless another fault occurs.
- Reset during HOLD discards the pending redirect.

## Structure
- Shared package pc_pkg: enum redirect_src_t {SRC_SEQ, SRC_BRANCH, SRC_JUMP, SRC_MRET, SRC_TRAP} ordered by priority; state enum {PC_RUN, PC_HOLD}.
- One sub-module: pc_src_arbiter (combinational priority select plus alignment check, returns src, target and fault). PC register, pending latch and FSM live in pc_gen.

## Test plan
- Reset: rst_n=0 one edge with trap_i=1 -> pc_o=32'h0000_0000, pending_o=0; release -> pc_o steps 0x0, 0x4, 0x8.
- Priority: branch_taken_i=1 (0x200), jump_i=1 (0x300), mret_i=1 (mepc 0x400) same cycle -> pc_o=0x400; trap_i added -> pc_o=0x100.
- Stalled redirect: stall_i=1, branch to 0x80 at pc 0x10, stall 3 cycles -> pc_o holds 0x10, pending_o=1; stall drops -> pc_o=0x80 next edge.
- Overwrite in HOLD: pending branch 0x80, then jump 0x90 while stalled, then branch 0xA0 while stalled -> after release pc_o=0x90.
- Misalignment (ALIGN_C=0): jump target 0x1002 -> pc_o=0x100, misalign_o=1 one cycle, fault_addr_o=0x1002; ALIGN_C=1 same target -> pc_o=0x1002, no fault; jump 0x1003 -> pc_o=0x1002 (bit 0 cleared).
- Wrap: pc_o=32'hFFFF_FFFC, no redirect -> pc_o=32'h0000_0000, pc_plus4_o=0x4.
